// File: rtl/dot_prod_pkg.sv
// Shared definitions for the dot-product request scheduler: default widths,
// the requester-ID width helper and the buffered result record.
package dot_prod_pkg;

   localparam int DEF_N_REQ          = 4;
   localparam int DEF_N_IN           = 8;
   localparam int DEF_DATA_WIDTH_IN  = 16;
   localparam int DEF_DATA_WIDTH_OUT = 38;
   localparam int DEF_ENG_LAT        = 1;

   // Width of a requester tag; a single requester still needs one bit of storage.
   function automatic int id_w(input int n_req);
      return (n_req < 2) ? 1 : $clog2(n_req);
   endfunction

   localparam int DEF_ID_W = id_w(DEF_N_REQ);

   // One buffered engine result together with the requester it belongs to.
   typedef struct packed {
      logic [DEF_ID_W-1:0]           id;
      logic [DEF_DATA_WIDTH_OUT-1:0] data;
   } res_t;

endpackage

// File: rtl/dot_prod_res_fifo.sv
// Two-entry result FIFO holding {requester id, engine result}.
// The head is presented directly from storage, so it stays put until popped;
// a simultaneous push and pop is accepted at any non-empty occupancy.
module dot_prod_res_fifo
   import dot_prod_pkg::*;
#(
   parameter int ID_W = DEF_ID_W,
   parameter int DW   = DEF_DATA_WIDTH_OUT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic [ID_W-1:0] i_push_id,
   input  logic [DW-1:0]   i_push_data,
   input  logic            i_pop,
   output logic            o_valid,
   output logic [ID_W-1:0] o_id,
   output logic [DW-1:0]   o_data,
   output logic [1:0]      o_count,
   output logic            o_full
);

   logic [1:0][ID_W-1:0] memId_q;
   logic [1:0][DW-1:0]   memData_q;
   logic                 wrPtr_q;
   logic                 rdPtr_q;
   logic [1:0]           count_q;
   logic [1:0]           count_d;
   logic                 popEn;
   logic                 pushEn;

   // Pops on an empty FIFO are ignored; a push into a full FIFO only lands when the head leaves in the same cycle.
   always_comb begin
      popEn   = i_pop & (count_q != 2'd0);
      pushEn  = i_push & ((count_q != 2'd2) | popEn);
      count_d = count_q;
      case ({pushEn, popEn})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointers; the write slot never aliases a live head except when that head is popping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         memId_q   <= '0;
         memData_q <= '0;
         wrPtr_q   <= 1'b0;
         rdPtr_q   <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (pushEn) begin
            memId_q[wrPtr_q]   <= i_push_id;
            memData_q[wrPtr_q] <= i_push_data;
            wrPtr_q            <= ~wrPtr_q;
         end
         if (popEn) begin
            rdPtr_q <= ~rdPtr_q;
         end
         count_q <= count_d;
      end
   end

   assign o_valid = (count_q != 2'd0);
   assign o_id    = memId_q[rdPtr_q];
   assign o_data  = memData_q[rdPtr_q];
   assign o_count = count_q;
   assign o_full  = (count_q == 2'd2);

endmodule

// File: rtl/dot_prod_sched.sv
// Round-robin scheduler sharing one fixed-latency dot-product engine among
// N_REQ requesters. Results come back tagged with the requester id through a
// two-entry FIFO; a grant is only issued when a FIFO slot is guaranteed.
// Build option: DOT_PROD_SCHED_PRIO_EN gives requester 0 absolute priority,
// the remaining requesters rotate among themselves.
module dot_prod_sched
   import dot_prod_pkg::*;
#(
   parameter int N_REQ          = DEF_N_REQ,
   parameter int N_IN           = DEF_N_IN,
   parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
   parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
   parameter int ENG_LAT        = DEF_ENG_LAT
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic [N_REQ-1:0]                          i_req_valid,
   input  logic [N_REQ-1:0][N_IN-1:0][DATA_WIDTH_IN-1:0] i_req_data,
   output logic [N_REQ-1:0]                          o_req_ready,
   output logic                                      o_eng_valid,
   output logic [N_IN-1:0][DATA_WIDTH_IN-1:0]        o_eng_data,
   input  logic                                      i_eng_valid,
   input  logic [DATA_WIDTH_OUT-1:0]                 i_eng_data,
   output logic                                      o_res_valid,
   output logic [DATA_WIDTH_OUT-1:0]                 o_res_data,
   output logic [id_w(N_REQ)-1:0]                    o_res_id,
   input  logic                                      i_res_ready,
   output logic                                      o_err
);

   localparam int                ID_W    = id_w(N_REQ);
   localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [ID_W:0]     NREQ_W  = (ID_W + 1)'(N_REQ);

   logic [1:0]                   sync_q;
   logic                         run;
   logic [ID_W-1:0]              rrPtr_q;
   logic [ID_W-1:0]              rrPtr_d;
   logic [ENG_LAT-1:0]           tagVld_q;
   logic [ENG_LAT-1:0][ID_W-1:0] tagId_q;
   logic                         err_q;
   logic                         err_d;

   logic [N_REQ-1:0]             cand;
   logic [ID_W:0]                idxW;
   logic                         rrFound;
   logic [ID_W-1:0]              rrIdx;
   logic                         selAny;
   logic                         selRr;
   logic [ID_W-1:0]              selIdx;
   logic                         issue;

   logic [2:0]                   inflight;
   logic [3:0]                   occupancy;
   logic                         creditOk;
   logic                         pop;
   logic                         push;
   logic [1:0]                   fifoCount;
   logic                         fifoFull;

   // Release from reset is re-timed through two flops so no grant races the deassertion edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign run = sync_q[1];

   // Credit: results still owed (in the engine or buffered) must leave room for one more, counting a head leaving this cycle.
   always_comb begin
      inflight = '0;
      for (int k = 0; k < ENG_LAT; k++) begin
         inflight = inflight + {2'b00, tagVld_q[k]};
      end
      pop       = o_res_valid & i_res_ready;
      occupancy = {2'b00, fifoCount} + {1'b0, inflight} - {3'b000, pop};
      creditOk  = (occupancy < 4'd2);
   end

   // Rotating search for the first valid requester at or after the round-robin pointer.
   always_comb begin
      cand    = i_req_valid;
      rrFound = 1'b0;
      rrIdx   = '0;
      idxW    = '0;
`ifdef DOT_PROD_SCHED_PRIO_EN
      cand[0] = 1'b0;
`endif
      for (int i = 0; i < N_REQ; i++) begin
         idxW = {1'b0, rrPtr_q} + (ID_W + 1)'(i);
         if (idxW >= NREQ_W) begin
            idxW = idxW - NREQ_W;
         end
         if (!rrFound && cand[idxW[ID_W-1:0]]) begin
            rrFound = 1'b1;
            rrIdx   = idxW[ID_W-1:0];
         end
      end
   end

   // Final selection, issue qualification and the pointer update (only rotating grants move the pointer).
   always_comb begin
      selAny = rrFound;
      selIdx = rrIdx;
      selRr  = rrFound;
`ifdef DOT_PROD_SCHED_PRIO_EN
      if (i_req_valid[0]) begin
         selAny = 1'b1;
         selIdx = '0;
         selRr  = 1'b0;
      end
`endif
      issue   = run & creditOk & selAny;
      rrPtr_d = rrPtr_q;
      if (issue && selRr) begin
         rrPtr_d = (selIdx == LAST_ID) ? '0 : selIdx + ID_W'(1);
      end
   end

   // One-hot ready and the granted operand vector; everything is zero when nothing is issued.
   always_comb begin
      o_req_ready = '0;
      o_eng_data  = '0;
      if (issue) begin
         o_req_ready[selIdx] = 1'b1;
         o_eng_data          = i_req_data[selIdx];
      end
   end

   assign o_eng_valid = issue;

   // Round-robin pointer register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rrPtr_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end

   // Tag pipe mirrors the engine latency so the returning result finds its requester id at the last stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tagVld_q <= '0;
         tagId_q  <= '0;
      end else begin
         tagVld_q[0] <= issue;
         tagId_q[0]  <= selIdx;
         for (int k = 1; k < ENG_LAT; k++) begin
            tagVld_q[k] <= tagVld_q[k-1];
            tagId_q[k]  <= tagId_q[k-1];
         end
      end
   end

   // A result with no matching tag is dropped and latches the error; so would a push that found no room.
   always_comb begin
      push  = i_eng_valid & tagVld_q[ENG_LAT-1];
      err_d = err_q
            | (i_eng_valid & ~tagVld_q[ENG_LAT-1])
            | (push & fifoFull & ~pop);
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;

   dot_prod_res_fifo #(
      .ID_W (ID_W),
      .DW   (DATA_WIDTH_OUT)
   ) u_res_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (push),
      .i_push_id   (tagId_q[ENG_LAT-1]),
      .i_push_data (i_eng_data),
      .i_pop       (pop),
      .o_valid     (o_res_valid),
      .o_id        (o_res_id),
      .o_data      (o_res_data),
      .o_count     (fifoCount),
      .o_full      (fifoFull)
   );

endmodule

// File: tb/tb_dot_prod_sched.sv
// Bench for dot_prod_sched: directed scenarios followed by random traffic,
// every cycle checked against a queue-based model of outstanding results.
module tb_dot_prod_sched;
   import dot_prod_pkg::*;

   localparam int N_REQ   = DEF_N_REQ;
   localparam int N_IN    = DEF_N_IN;
   localparam int DW_IN   = DEF_DATA_WIDTH_IN;
   localparam int DW_OUT  = DEF_DATA_WIDTH_OUT;
   localparam int ENG_LAT = DEF_ENG_LAT;
   localparam int ID_W    = DEF_ID_W;

   typedef logic [N_IN-1:0][DW_IN-1:0] vec_t;
   typedef struct {
      res_t r;
      int   rdy;
   } expItem_t;

   logic                          clk = 1'b0;
   logic                          rstN = 1'b1;
   logic [N_REQ-1:0]              reqValid = '0;
   logic [N_REQ-1:0][N_IN-1:0][DW_IN-1:0] reqData = '0;
   logic [N_REQ-1:0]              o_req_ready;
   logic                          o_eng_valid;
   vec_t                          o_eng_data;
   logic                          iEngValid;
   logic [DW_OUT-1:0]             iEngData;
   logic                          o_res_valid;
   logic [DW_OUT-1:0]             o_res_data;
   logic [ID_W-1:0]               o_res_id;
   logic                          resReady = 1'b0;
   logic                          o_err;
   logic                          inj = 1'b0;

   logic [ENG_LAT-1:0]            engV = '0;
   logic [DW_OUT-1:0]             engD [ENG_LAT];

   int                            total = 0;
   int                            bad = 0;
   int                            cyc = 0;
   int                            runCnt = 0;
   int                            mPtr = 0;
   logic                          errExp = 1'b0;
   expItem_t                      q[$];
   int                            nGnt = 0;
   logic [N_REQ-1:0]              sReady;
   logic                          sResValid;
   int                            popIds[$];
   int                            popCyc[$];
   logic [DW_OUT-1:0]             popData[$];

   always #5 clk = ~clk;

   dot_prod_sched dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_req_valid (reqValid),
      .i_req_data  (reqData),
      .o_req_ready (o_req_ready),
      .o_eng_valid (o_eng_valid),
      .o_eng_data  (o_eng_data),
      .i_eng_valid (iEngValid),
      .i_eng_data  (iEngData),
      .o_res_valid (o_res_valid),
      .o_res_data  (o_res_data),
      .o_res_id    (o_res_id),
      .i_res_ready (resReady),
      .o_err       (o_err)
   );

   // External engine: weighted sum of squares, so all-1 operands give 36 and all-2 give 144.
   function automatic logic [DW_OUT-1:0] engModel(input vec_t v);
      longint s = 0;
      for (int k = 0; k < N_IN; k++) begin
         s += longint'(k + 1) * longint'(v[k]) * longint'(v[k]);
      end
      return DW_OUT'(s);
   endfunction

   // Fixed-latency engine pipe with an optional stray-result injection.
   always @(posedge clk) begin
      engV[0] <= o_eng_valid;
      engD[0] <= engModel(o_eng_data);
      for (int k = 1; k < ENG_LAT; k++) begin
         engV[k] <= engV[k-1];
         engD[k] <= engD[k-1];
      end
   end

   assign iEngValid = engV[ENG_LAT-1] | inj;
   assign iEngData  = inj ? DW_OUT'(38'h155) : engD[ENG_LAT-1];

   // Arbitration rule: first valid requester at or after the pointer (requester 0 first under priority).
   function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
`ifdef DOT_PROD_SCHED_PRIO_EN
      if (v[0]) return 0;
      v[0] = 1'b0;
`endif
      for (int i = 0; i < N_REQ; i++) begin
         int j = (ptr + i) % N_REQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic rdy);
      reqValid = v;
      resReady = rdy;
   endtask

   task automatic setOps(input int r, input int val);
      for (int k = 0; k < N_IN; k++) reqData[r][k] = DW_IN'(val);
   endtask

   // One clock: check the cycle at the falling edge against the model, then advance the model.
   task automatic stepCycle();
      bit               expVld;
      bit               expPop;
      int               g;
      logic [N_REQ-1:0] expReady;
      expItem_t         it;
      @(negedge clk);
      cyc++;
      if (rstN) runCnt++;
      else runCnt = 0;
      expVld = (q.size() > 0) && (q[0].rdy <= cyc);
      checkOutput("res_valid", o_res_valid, expVld);
      if (expVld) begin
         checkOutput("res_id", o_res_id, q[0].r.id);
         checkOutput("res_data", o_res_data, q[0].r.data);
      end
      expPop = expVld && resReady;
      g = -1;
      if (runCnt >= 3 && (q.size() - int'(expPop)) < 2) g = pick(reqValid, mPtr);
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      checkOutput("req_ready", o_req_ready, expReady);
      checkOutput("eng_valid", o_eng_valid, g >= 0);
      if (g >= 0) checkOutput("eng_data", o_eng_data, reqData[g]);
      checkOutput("err", o_err, errExp);
      sReady    = o_req_ready;
      sResValid = o_res_valid;
      if (o_req_ready != '0) nGnt++;
      if (o_res_valid && resReady) begin
         popIds.push_back(int'(o_res_id));
         popCyc.push_back(cyc);
         popData.push_back(o_res_data);
      end
      if (expPop) void'(q.pop_front());
      if (g >= 0) begin
         it.r.id   = ID_W'(g);
         it.r.data = engModel(reqData[g]);
         it.rdy    = cyc + ENG_LAT + 1;
         q.push_back(it);
`ifdef DOT_PROD_SCHED_PRIO_EN
         if (g != 0) mPtr = (g + 1) % N_REQ;
`else
         mPtr = (g + 1) % N_REQ;
`endif
      end
      if (inj) errExp = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      #1;
      checkOutput("rst_ready", o_req_ready, '0);
      checkOutput("rst_eng_valid", o_eng_valid, '0);
      checkOutput("rst_eng_data", o_eng_data, '0);
      checkOutput("rst_res_valid", o_res_valid, '0);
      checkOutput("rst_res_id", o_res_id, '0);
      checkOutput("rst_res_data", o_res_data, '0);
      checkOutput("rst_err", o_err, '0);
      q.delete();
      mPtr   = 0;
      errExp = 1'b0;
      runCnt = 0;
      stepCycle();
      stepCycle();
      rstN = 1'b1;
   endtask

   task automatic drain();
      applyStimulus('0, 1'b1);
      for (int i = 0; i < 20 && q.size() > 0; i++) stepCycle();
      checkOutput("drain", q.size(), 0);
      for (int i = 0; i < ENG_LAT + 1; i++) stepCycle();
   endtask

   initial begin
      int expIds[5] = '{0, 1, 2, 3, 0};
      #1;
      doReset();

      // Requester 2 alone with unit operands.
      for (int r = 0; r < N_REQ; r++) setOps(r, 1);
      applyStimulus(4'b0100, 1'b1);
      stepCycle();
      stepCycle();
      checkOutput("s1_no_early_grant", sReady, '0);
      stepCycle();
      checkOutput("s1_grant", sReady, 4'b0100);
      applyStimulus('0, 1'b1);
      stepCycle();
      checkOutput("s1_not_yet", sResValid, 1'b0);
      checkOutput("s1_valid", o_res_valid, 1'b1);
      checkOutput("s1_id", o_res_id, 2);
      checkOutput("s1_data", o_res_data, 36);
      stepCycle();

      // All requesters, operands 2, consumer always ready.
      doReset();
      for (int r = 0; r < N_REQ; r++) setOps(r, 2);
      popIds.delete(); popCyc.delete(); popData.delete();
      applyStimulus('1, 1'b1);
      for (int i = 0; i < 12; i++) stepCycle();
      checkOutput("s2_npops", popIds.size() >= 5, 1);
      if (popIds.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput("s2_id", popIds[i], expIds[i]);
            checkOutput("s2_data", popData[i], 144);
            if (i > 0) checkOutput("s2_back_to_back", popCyc[i] - popCyc[i-1], 1);
         end
      end

      // Consumer stalled: only two grants, then resume.
      drain();
      nGnt = 0;
      applyStimulus('1, 1'b0);
      for (int i = 0; i < 8; i++) stepCycle();
      checkOutput("s3_grants", nGnt, 2);
      checkOutput("s3_stall", sReady, '0);
      nGnt = 0;
      applyStimulus('1, 1'b1);
      for (int i = 0; i < 8; i++) stepCycle();
      checkOutput("s3_resume", nGnt >= 4, 1);

      // Stray engine result with nothing in flight.
      drain();
      inj = 1'b1;
      stepCycle();
      inj = 1'b0;
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("s4_err", o_err, 1'b1);
      checkOutput("s4_no_push", o_res_valid, 1'b0);

      // Reset with results outstanding.
      for (int r = 0; r < N_REQ; r++)
         for (int k = 0; k < N_IN; k++) reqData[r][k] = DW_IN'($urandom);
      applyStimulus('1, 1'b0);
      for (int i = 0; i < 4; i++) stepCycle();
      checkOutput("s5_buffered", o_res_valid, 1'b1);
      doReset();
      applyStimulus('0, 1'b1);
      for (int i = 0; i < 4; i++) stepCycle();
      checkOutput("s5_res_quiet", sResValid, 1'b0);
      applyStimulus('1, 1'b1);
      stepCycle();
      checkOutput("s5_ptr_zero", sReady, 4'b0001);

`ifdef DOT_PROD_SCHED_PRIO_EN
      drain();
      applyStimulus(4'b0011, 1'b1);
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("s6_prio", sReady, 4'b0001);
      end
      applyStimulus(4'b0010, 1'b1);
      stepCycle();
      checkOutput("s6_next", sReady, 4'b0010);
`endif

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         for (int r = 0; r < N_REQ; r++)
            for (int k = 0; k < N_IN; k++) reqData[r][k] = DW_IN'($urandom);
         applyStimulus(N_REQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
         stepCycle();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
